// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU.
//   - Opcode encodings (OP_*) for alu_control.
//   - FSM state enum alu_state_t; the MUL state exists only when ALU_MUL_EN
//     is defined.
//   - add_ovf(): signed-overflow helper for the adder.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_NAND = 4'b1101;
    localparam logic [3:0] OP_MUL  = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_DONE = 2'b01
`ifdef ALU_MUL_EN
        ,
        S_MUL  = 2'b10
`endif
    } alu_state_t;

    // Same-sign operands giving an opposite-sign sum is exactly
    // carry-in XOR carry-out of the MSB.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                     input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative unsigned shift-add multiplier, one partial product
// per clock, WIDTH iterations.
// Ports:
//   clk, rst_n      clock, async active-low reset (aborts a multiply)
//   start_i         load operands and begin; overrides any multiply in flight
//   mcand_i         multiplicand, sampled on start_i
//   mplier_i        multiplier, sampled on start_i
//   acc_o           2*WIDTH accumulator (full product once done_o pulses)
//   done_o          one-cycle pulse the cycle after the last iteration
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     mcand_i,
    input  logic [WIDTH-1:0]     mplier_i,
    output logic [2*WIDTH-1:0]   acc_o,
    output logic                 done_o
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;

    // Shift-add datapath: multiplicand moves left, multiplier moves right.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= {(2*WIDTH){1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= {{WIDTH{1'b0}}, mcand_i};
            mplier_q <= mplier_i;
            acc_q    <= {(2*WIDTH){1'b0}};
            cnt_q    <= CNT_W'(WIDTH-1);
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else if (busy_q) begin
            acc_q    <= acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
            mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
            if (cnt_q == CNT_W'(0)) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end else begin
                cnt_q  <= cnt_q - CNT_W'(1);
                done_q <= 1'b0;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign acc_o  = acc_q;
    assign done_o = done_q;

endmodule

// File: rtl/alu_mc.sv
// alu_mc: parametrised multi-cycle ALU with valid/ready handshakes and
// registered result/flags.
// Build option: define ALU_MUL_EN to include the iterative multiplier
// (opcode 4'b1000, WIDTH+1 cycle latency). Without it, 4'b1000 is an
// undefined single-cycle opcode.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   in_valid / in_ready      request handshake
//   src1, src2, alu_control  operands and opcode, sampled on handshake
//   out_valid / out_ready    result handshake
//   result, zero, cout, overflow   registered result and flags
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);
    alu_state_t        state_q, state_d;
    logic [WIDTH-1:0]  result_q;
    logic              zero_q, cout_q, overflow_q;

    logic [WIDTH-1:0]  a_s, b_s, alu_res_s;
    logic [WIDTH:0]    sum_s;
    logic              add_ovf_s, alu_cout_s, alu_ovf_s;
    logic              accept_s, load_single_s;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] product_s;
    logic               mul_done_s, start_mul_s, load_mul_s;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_mul_s),
        .mcand_i  (src1),
        .mplier_i (src2),
        .acc_o    (product_s),
        .done_o   (mul_done_s)
    );
`endif

    // Operand conditioning and shared adder; bit 2 both inverts B and
    // supplies the carry-in, giving two's-complement subtraction.
    assign a_s       = src1 ^ {WIDTH{alu_control[3]}};
    assign b_s       = src2 ^ {WIDTH{alu_control[2]}};
    assign sum_s     = {1'b0, a_s} + {1'b0, b_s} + {{WIDTH{1'b0}}, alu_control[2]};
    assign add_ovf_s = add_ovf(a_s[WIDTH-1], b_s[WIDTH-1], sum_s[WIDTH-1]);

    // Single-cycle result and flag selection by opcode.
    always_comb begin
        alu_res_s  = {WIDTH{1'b0}};
        alu_cout_s = 1'b0;
        alu_ovf_s  = 1'b0;
        case (alu_control)
            OP_AND:  alu_res_s = a_s & b_s;
            OP_OR:   alu_res_s = a_s | b_s;
            OP_NOR:  alu_res_s = a_s & b_s;   // ~A & ~B
            OP_NAND: alu_res_s = a_s | b_s;   // ~A | ~B
            OP_ADD, OP_SUB: begin
                alu_res_s  = sum_s[WIDTH-1:0];
                alu_cout_s = sum_s[WIDTH];
                alu_ovf_s  = add_ovf_s;
            end
            OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, sum_s[WIDTH-1] ^ add_ovf_s};
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept_s = in_valid && in_ready;

    // Next-state logic and load strobes for the output registers.
    always_comb begin
        state_d       = state_q;
        load_single_s = 1'b0;
`ifdef ALU_MUL_EN
        start_mul_s   = 1'b0;
        load_mul_s    = 1'b0;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_s) begin
`ifdef ALU_MUL_EN
                    if (alu_control == OP_MUL) begin
                        state_d     = S_MUL;
                        start_mul_s = 1'b1;
                    end else begin
                        state_d       = S_DONE;
                        load_single_s = 1'b1;
                    end
`else
                    state_d       = S_DONE;
                    load_single_s = 1'b1;
`endif
                end else if ((state_q == S_DONE) && out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
`ifdef ALU_MUL_EN
            S_MUL: begin
                if (mul_done_s) begin
                    state_d    = S_DONE;
                    load_mul_s = 1'b1;
                end else begin
                    state_d = S_MUL;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Result/flag registers; they only change on a load, so they hold while
    // the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q   <= {WIDTH{1'b0}};
            zero_q     <= 1'b0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else if (load_single_s) begin
            result_q   <= alu_res_s;
            zero_q     <= (alu_res_s == {WIDTH{1'b0}});
            cout_q     <= alu_cout_s;
            overflow_q <= alu_ovf_s;
`ifdef ALU_MUL_EN
        end else if (load_mul_s) begin
            result_q   <= product_s[WIDTH-1:0];
            zero_q     <= (product_s[WIDTH-1:0] == {WIDTH{1'b0}});
            cout_q     <= 1'b0;
            overflow_q <= (product_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
`endif
        end else begin
            result_q   <= result_q;
            zero_q     <= zero_q;
            cout_q     <= cout_q;
            overflow_q <= overflow_q;
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign cout      = cout_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  src1, src2, result;
    logic [3:0]    alu_control;
    logic          zero, cout, overflow;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic          m_valid;
    int            m_left;          // edges remaining until a multiply result appears
    logic [W-1:0]  m_res, p_res;
    logic          m_zero, m_cout, m_ovf, p_ovf;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .src1(src1), .src2(src2), .alu_control(alu_control),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .cout(cout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_mul(input logic [3:0] op);
`ifdef ALU_MUL_EN
        return op == 4'b1000;
`else
        return 1'b0;
`endif
    endfunction

    // Reference arithmetic from the opcode definitions, using wide integers.
    task automatic ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] r, output logic c, output logic v);
        logic [63:0] wide;
        longint sa, sb, ss;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin
                wide = {32'd0, a} + {32'd0, b};
                r = wide[31:0]; c = wide[32];
                ss = sa + sb; v = (ss > SMAX) || (ss < SMIN);
            end
            4'b0110: begin
                r = a - b; c = (a >= b);
                ss = sa - sb; v = (ss > SMAX) || (ss < SMIN);
            end
            4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
            4'b1100: r = ~(a | b);
            4'b1101: r = ~(a & b);
`ifdef ALU_MUL_EN
            4'b1000: begin
                wide = {32'd0, a} * {32'd0, b};
                r = wide[31:0]; v = (wide[63:32] != 32'd0);
            end
`endif
            default: r = '0;
        endcase
    endtask

    // One clock: drive inputs, check in_ready, advance model, check outputs.
    task automatic step(input logic v, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ordy);
        logic m_rdy, acc, c, o;
        logic [W-1:0] r;
        in_valid = v; alu_control = op; src1 = a; src2 = b; out_ready = ordy;
        #1;
        m_rdy = (m_left == 0) && (!m_valid || ordy);
        check("in_ready", in_ready, m_rdy);
        acc = v && m_rdy;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_valid = 1'b1; m_res = p_res; m_zero = (p_res == '0);
                m_cout = 1'b0; m_ovf = p_ovf;
            end
        end else if (m_valid && !ordy) begin
            m_valid = 1'b1;
        end else if (acc) begin
            ref_op(op, a, b, r, c, o);
            if (is_mul(op)) begin
                m_valid = 1'b0; m_left = W + 1; p_res = r; p_ovf = o;
            end else begin
                m_valid = 1'b1; m_res = r; m_zero = (r == '0); m_cout = c; m_ovf = o;
            end
        end else begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check("out_valid", out_valid, m_valid);
        if (m_valid) begin
            check("result", result, m_res);
            check("zero", zero, m_zero);
            check("cout", cout, m_cout);
            check("overflow", overflow, m_ovf);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_result"}, result, 32'd0);
        check({tag, "_zero"}, zero, 1'b0);
        check({tag, "_cout"}, cout, 1'b0);
        check({tag, "_overflow"}, overflow, 1'b0);
        check({tag, "_in_ready"}, in_ready, 1'b1);
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        m_valid = 1'b0; m_left = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Waits for a multiply result, bounded; returns edges after the handshake.
    task automatic wait_mul(output int n);
        n = 0;
        while (!out_valid && n < 60) begin
            step(1'b0, 4'b0000, 32'd0, 32'd0, 1'b1);
            n++;
        end
    endtask

    logic [3:0] ops [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                             4'b1100, 4'b1101, 4'b1000, 4'b1010, 4'b0011};

    initial begin
        logic [W-1:0] held, a, b;
        int n;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        src1 = '0; src2 = '0; alu_control = 4'b0000;
        m_valid = 1'b0; m_left = 0; m_res = '0; p_res = '0;
        m_zero = 1'b0; m_cout = 1'b0; m_ovf = 1'b0; p_ovf = 1'b0;
        @(negedge clk); @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // ADD overflow into the sign bit
        step(1'b1, 4'b0010, 32'h7FFFFFFF, 32'd1, 1'b1);
        check("add_lit_res", result, 32'h80000000);
        check("add_lit_ovf", overflow, 1'b1);
        check("add_lit_cout", cout, 1'b0);
        check("add_lit_zero", zero, 1'b0);
        // SUB equal operands
        step(1'b1, 4'b0110, 32'd5, 32'd5, 1'b1);
        check("sub_lit_res", result, 32'd0);
        check("sub_lit_zero", zero, 1'b1);
        check("sub_lit_cout", cout, 1'b1);
        // SLT -1 < 1
        step(1'b1, 4'b0111, 32'hFFFFFFFF, 32'd1, 1'b1);
        check("slt_lit_res", result, 32'd1);

        // Back-to-back ADD, OR, NOR
        step(1'b1, 4'b0010, 32'd10, 32'd20, 1'b1);
        check("b2b_valid_add", out_valid, 1'b1);
        step(1'b1, 4'b0001, 32'hF0, 32'h0F, 1'b1);
        check("b2b_valid_or", out_valid, 1'b1);
        check("b2b_lit_or", result, 32'hFF);
        step(1'b1, 4'b1100, 32'hFFFF0000, 32'h0000FF00, 1'b1);
        check("b2b_valid_nor", out_valid, 1'b1);
        check("b2b_lit_nor", result, 32'h000000FF);
        held = 32'h000000FF;
        // Stall the consumer for 3 cycles
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'b0010, $urandom, $urandom, 1'b0);
            check("hold_result", result, held);
            check("hold_in_ready", in_ready, 1'b0);
        end
        step(1'b0, 4'b0000, 32'd0, 32'd0, 1'b1);

`ifdef ALU_MUL_EN
        step(1'b1, 4'b1000, 32'h00010000, 32'h00010000, 1'b1);
        wait_mul(n);
        check("mul_latency", n, 33);
        check("mul_lit_res", result, 32'd0);
        check("mul_lit_ovf", overflow, 1'b1);
        step(1'b1, 4'b1000, 32'd1234, 32'd5678, 1'b1);
        wait_mul(n);
        check("mul2_latency", n, 33);
        check("mul2_lit_res", result, 32'd7006652);
        check("mul2_lit_ovf", overflow, 1'b0);
        // Abort a multiply with reset
        step(1'b1, 4'b1000, 32'd77, 32'd99, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b0, 4'b0000, 32'd0, 32'd0, 1'b1);
        pulse_reset();
`else
        step(1'b1, 4'b1000, 32'd7, 32'd9, 1'b1);
        check("nomul_valid", out_valid, 1'b1);
        check("nomul_res", result, 32'd0);
        check("nomul_zero", zero, 1'b1);
        step(1'b1, 4'b0010, 32'd40, 32'd2, 1'b1);
        pulse_reset();
`endif
        step(1'b1, 4'b0010, 32'd2, 32'd3, 1'b1);
        check("post_rst_add", result, 32'd5);
        step(1'b1, 4'b1010, 32'h1234, 32'h5678, 1'b1);
        check("undef_res", result, 32'd0);
        check("undef_zero", zero, 1'b1);

        // Randomised traffic with random stalls
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 3))
                0: a = 32'h7FFFFFFF;
                1: a = 32'h80000000;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) b = {16'd0, b[15:0]};
            step($urandom_range(0, 2) != 0, ops[$urandom_range(0, 9)], a, b,
                 $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
